pipe_hazard_seq: RTL and testbench

PIPE_HAZARD_SEQ -- requirements
Module: pipe_hazard_seq

---
 rtl/pipe_hazard_seq_pkg.sv | 19 +
 rtl/pipe_hazard_seq_if.sv | 36 +++
 rtl/hazard_detect.sv | 16 +
 rtl/pipe_hazard_seq.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_seq_pkg.sv
// Shared encodings for the pipeline hazard sequencer: PC-select codes, FSM state type
// and the width of the memory-wait counter.
package pipe_hazard_seq_pkg;

  localparam logic [2:0] PC_SEL_SEQ  = 3'b000;
  localparam logic [2:0] PC_SEL_BR   = 3'b001;
  localparam logic [2:0] PC_SEL_JAL  = 3'b010;
  localparam logic [2:0] PC_SEL_JALR = 3'b011;

  // MEM_TIMEOUT is limited to 1..15, so four bits always suffice
  localparam int unsigned WaitCntW = 4;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StErr
  } state_e;

endpackage

// File: rtl/pipe_hazard_seq_if.sv
// Hazard-control bus between the pipeline datapath (master) and the sequencer (slave).
interface pipe_hazard_seq_if;

  logic       cond_hand_out;
  logic       jal;
  logic       jalr;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       mem_busy;
  logic       mem_ready;

  logic [2:0] pc_sel;
  logic       pc_we;
  logic       if_id_we;
  logic       ex_mem_we;
  logic       if_id_reset;
  logic       id_ex_reset;
  logic       mem_err;

  modport master (
    output cond_hand_out, jal, jalr, ex_mem_read, ex_rd, id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2, mem_busy, mem_ready,
    input  pc_sel, pc_we, if_id_we, ex_mem_we, if_id_reset, id_ex_reset, mem_err
  );

  modport slave (
    input  cond_hand_out, jal, jalr, ex_mem_read, ex_rd, id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2, mem_busy, mem_ready,
    output pc_sel, pc_we, if_id_we, ex_mem_we, if_id_reset, id_ex_reset, mem_err
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds an operand in ID.
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       load_use
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipe_hazard_seq.sv
// Pipeline hazard sequencer: redirects, load-use bubbles, memory-wait freeze and timeout.
// Optional stall/flush performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_seq
  import pipe_hazard_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_seq_if.slave bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [WaitCntW-1:0] TimeoutCnt = WaitCntW'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [WaitCntW-1:0] wait_q, wait_d;
  logic                frozen;
  logic                load_use;

  logic [2:0] pc_sel;
  logic       pc_we, if_id_we, ex_mem_we;
  logic       if_id_reset, id_ex_reset;

  hazard_detect u_hazard_detect (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .load_use    (load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    frozen  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.mem_busy) begin
          frozen  = 1'b1;
          state_d = StMemWait;
          wait_d  = WaitCntW'(1);
        end
      end
      StMemWait: begin
        // mem_ready beats a coincident timeout; the exit cycle behaves as RUN
        if (bus.mem_ready) begin
          state_d = StRun;
        end else begin
          frozen = 1'b1;
          if (wait_q == TimeoutCnt) begin
            state_d = StErr;
          end else begin
            wait_d = wait_q + WaitCntW'(1);
          end
        end
      end
      StErr:   state_d = StErr;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    pc_sel      = PC_SEL_SEQ;
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    ex_mem_we   = 1'b1;
    if_id_reset = 1'b0;
    id_ex_reset = 1'b0;
    if (reset || (state_q == StErr)) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      ex_mem_we   = 1'b0;
      if_id_reset = 1'b1;
      id_ex_reset = 1'b1;
    end else if (frozen) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      ex_mem_we = 1'b0;
    end else if (bus.cond_hand_out) begin
      pc_sel      = PC_SEL_BR;
      if_id_reset = 1'b1;
      id_ex_reset = 1'b1;
    end else if (bus.jalr) begin
      pc_sel      = PC_SEL_JALR;
      if_id_reset = 1'b1;
    end else if (bus.jal) begin
      pc_sel      = PC_SEL_JAL;
      if_id_reset = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_reset = 1'b1;
    end
  end

  assign bus.pc_sel      = pc_sel;
  assign bus.pc_we       = pc_we;
  assign bus.if_id_we    = if_id_we;
  assign bus.ex_mem_we   = ex_mem_we;
  assign bus.if_id_reset = if_id_reset;
  assign bus.id_ex_reset = id_ex_reset;
  assign bus.mem_err     = !reset && (state_q == StErr);

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((if_id_reset || id_ex_reset) && (state_q != StErr) &&
          (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_hazard_seq.sv
// Directed bench for pipe_hazard_seq: reset, redirect priority, load-use, memory wait and timeout.
module tb_pipe_hazard_seq;

  // {pc_sel, pc_we, if_id_we, ex_mem_we, if_id_reset, id_ex_reset, mem_err}
  localparam logic [8:0] EXP_RST  = 9'b000_000_11_0;
  localparam logic [8:0] EXP_RUN  = 9'b000_111_00_0;
  localparam logic [8:0] EXP_BR   = 9'b001_111_11_0;
  localparam logic [8:0] EXP_JAL  = 9'b010_111_10_0;
  localparam logic [8:0] EXP_JALR = 9'b011_111_10_0;
  localparam logic [8:0] EXP_LU   = 9'b000_001_01_0;
  localparam logic [8:0] EXP_FRZ  = 9'b000_000_00_0;
  localparam logic [8:0] EXP_ERR  = 9'b000_000_11_1;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] outs;
  int         errors = 0;
  int         checks = 0;

  pipe_hazard_seq_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
  pipe_hazard_seq #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  pipe_hazard_seq #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
`endif

  always #5 clk = ~clk;

  assign outs = {bus.pc_sel, bus.pc_we, bus.if_id_we, bus.ex_mem_we,
                 bus.if_id_reset, bus.id_ex_reset, bus.mem_err};

  task automatic drive_idle();
    bus.cond_hand_out = 1'b0;
    bus.jal           = 1'b0;
    bus.jalr          = 1'b0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_rd         = 5'd0;
    bus.id_rs1        = 5'd0;
    bus.id_rs2        = 5'd0;
    bus.id_use_rs1    = 1'b0;
    bus.id_use_rs2    = 1'b0;
    bus.mem_busy      = 1'b0;
    bus.mem_ready     = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_idle();
    #1;
    checks++;
    if (outs !== EXP_RST) begin
      errors++; $display("FAIL reset_idle: got %b want %b", outs, EXP_RST);
    end
    bus.cond_hand_out = 1'b1;
    bus.jal           = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_RST) begin
      errors++; $display("FAIL reset_with_branch: got %b want %b", outs, EXP_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #1;
    checks++;
    if (outs !== EXP_RUN) begin
      errors++; $display("FAIL reset_release: got %b want %b", outs, EXP_RUN);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_LU) begin
      errors++; $display("FAIL lu_rs1: got %b want %b", outs, EXP_LU);
    end
    @(negedge clk);
    bus.ex_mem_read = 1'b0;
    #1;
    checks++;
    if (outs !== EXP_RUN) begin
      errors++; $display("FAIL lu_release: got %b want %b", outs, EXP_RUN);
    end
    @(negedge clk);
    drive_idle();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rs2 = 5'd9; bus.id_use_rs2 = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_LU) begin
      errors++; $display("FAIL lu_rs2: got %b want %b", outs, EXP_LU);
    end
    bus.id_use_rs2 = 1'b0;
    #1;
    checks++;
    if (outs !== EXP_RUN) begin
      errors++; $display("FAIL lu_rs2_unused: got %b want %b", outs, EXP_RUN);
    end
    @(negedge clk);
    drive_idle();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_RUN) begin
      errors++; $display("FAIL lu_x0: got %b want %b", outs, EXP_RUN);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_priority();
    @(negedge clk);
    bus.cond_hand_out = 1'b1; bus.jal = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_BR) begin
      errors++; $display("FAIL pri_br_over_jal: got %b want %b", outs, EXP_BR);
    end
    @(negedge clk);
    drive_idle();
    bus.jalr = 1'b1; bus.jal = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_JALR) begin
      errors++; $display("FAIL pri_jalr_over_jal: got %b want %b", outs, EXP_JALR);
    end
    @(negedge clk);
    drive_idle();
    bus.jal = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3; bus.id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_JAL) begin
      errors++; $display("FAIL pri_jal_over_lu: got %b want %b", outs, EXP_JAL);
    end
    @(negedge clk);
    drive_idle();
    bus.mem_busy = 1'b1; bus.cond_hand_out = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_FRZ) begin
      errors++; $display("FAIL pri_busy_over_br: got %b want %b", outs, EXP_FRZ);
    end
    @(negedge clk);
    drive_idle();
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_RUN) begin
      errors++; $display("FAIL pri_wait_exit: got %b want %b", outs, EXP_RUN);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_mem_wait();
    pulse_reset();
    bus.mem_busy = 1'b1; bus.cond_hand_out = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_FRZ) begin
      errors++; $display("FAIL mw_busy_cycle: got %b want %b", outs, EXP_FRZ);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.mem_busy = 1'b0;
      bus.jal = (i == 2);
      bus.ex_mem_read = (i == 3); bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1'b1;
      #1;
      checks++;
      if (outs !== EXP_FRZ) begin
        errors++; $display("FAIL mw_frozen[%0d]: got %b want %b", i, outs, EXP_FRZ);
      end
    end
    @(negedge clk);
    drive_idle();
    bus.cond_hand_out = 1'b1; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_BR) begin
      errors++; $display("FAIL mw_exit_branch: got %b want %b", outs, EXP_BR);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (outs !== EXP_RUN) begin
      errors++; $display("FAIL mw_after_exit: got %b want %b", outs, EXP_RUN);
    end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 16'd4) begin
      errors++; $display("FAIL mw_stall_cnt: got %0d want 4", stall_cnt);
    end
    checks++;
    if (flush_cnt !== 16'd1) begin
      errors++; $display("FAIL mw_flush_cnt: got %0d want 1", flush_cnt);
    end
`endif
  endtask

  task automatic test_timeout();
    @(negedge clk);
    drive_idle();
    bus.mem_busy = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_FRZ) begin
      errors++; $display("FAIL tmo_busy: got %b want %b", outs, EXP_FRZ);
    end
    @(negedge clk);
    bus.mem_busy = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      #1;
      checks++;
      if (outs !== EXP_FRZ) begin
        errors++; $display("FAIL tmo_wait[%0d]: got %b want %b", i, outs, EXP_FRZ);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (outs !== EXP_ERR) begin
      errors++; $display("FAIL tmo_err: got %b want %b", outs, EXP_ERR);
    end
    @(negedge clk);
    bus.mem_ready = 1'b1; bus.cond_hand_out = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_ERR) begin
      errors++; $display("FAIL tmo_err_sticky: got %b want %b", outs, EXP_ERR);
    end
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_RST) begin
      errors++; $display("FAIL tmo_reset: got %b want %b", outs, EXP_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== EXP_RUN) begin
      errors++; $display("FAIL tmo_after_reset: got %b want %b", outs, EXP_RUN);
    end
  endtask

  task automatic test_ready_at_timeout();
    @(negedge clk);
    drive_idle();
    bus.mem_busy = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      bus.mem_busy = 1'b0;
    end
    @(negedge clk);
    bus.mem_ready = 1'b1; bus.jal = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_JAL) begin
      errors++; $display("FAIL rdy_at_tmo: got %b want %b", outs, EXP_JAL);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (outs !== EXP_RUN) begin
      errors++; $display("FAIL rdy_at_tmo_next: got %b want %b", outs, EXP_RUN);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    drive_idle();
    bus.mem_busy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      bus.mem_busy = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_RST) begin
      errors++; $display("FAIL rmw_reset: got %b want %b", outs, EXP_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== EXP_RUN) begin
      errors++; $display("FAIL rmw_release: got %b want %b", outs, EXP_RUN);
    end
    bus.jalr = 1'b1;
    #1;
    checks++;
    if (outs !== EXP_JALR) begin
      errors++; $display("FAIL rmw_jalr: got %b want %b", outs, EXP_JALR);
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_load_use();
    test_priority();
    test_mem_wait();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
